jtag_mem_burst_bridge: RTL

- Clock-domain-side engine behind the debug TAP. Turns burst commands (write/read, start address, length) into word transactions on a TCDM/OBI-style memory port toward L2.
- Generalises single-word JTAG L2 access: parametrised address/data width, bursts up to MAX_BURST words, buffered read return with back-pressure, misalignment error reporting.
- Command and write-data streams arrive from the TAP CDC FIFOs; read data returns through the rdata stream.

---
 rtl/jtag_mem_burst_bridge_pkg.sv | 36 +++
 rtl/jtag_mem_burst_bridge_if.sv | 66 ++++++
 rtl/jtag_bridge_rd_fifo.sv | 56 +++++
 rtl/jtag_mem_burst_bridge.sv | 129 ++++++++++++
 4 files changed

// File: rtl/jtag_mem_burst_bridge_pkg.sv
// -----------------------------------------------------------------------------
// jtag_bridge_pkg
// Shared types and helpers for the JTAG memory burst bridge.
//   state_e  : burst engine state
//   cmd_t    : burst command record {we, addr, len} at the default geometry
//   be_width : bytes per data word
//   off_bits : number of byte-offset address bits inside one word
// -----------------------------------------------------------------------------
package jtag_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DRAIN,
      ST_ERR
   } state_e;

   localparam int unsigned CMD_ADDR_W = 32;
   localparam int unsigned CMD_LEN_W  = 8;

   typedef struct packed {
      logic                  we;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_LEN_W-1:0]  len;
   } cmd_t;

   function automatic int unsigned be_width(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned off_bits(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/jtag_mem_burst_bridge_if.sv
// -----------------------------------------------------------------------------
// jtag_mem_burst_bridge_if
// Bundles the command, write-data, read-data, memory and status signals of the
// burst bridge. Signal suffixes are from the bridge's point of view.
//   slave  : the bridge itself
//   master : the environment (TAP FIFOs + memory)
// -----------------------------------------------------------------------------
interface jtag_mem_burst_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic                  cmd_we_i;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [LEN_WIDTH-1:0]  cmd_len_i;

   logic                  wdata_valid_i;
   logic                  wdata_ready_o;
   logic [DATA_WIDTH-1:0] wdata_i;

   logic                  rdata_valid_o;
   logic                  rdata_ready_i;
   logic [DATA_WIDTH-1:0] rdata_o;

   logic                  mem_req_o;
   logic                  mem_gnt_i;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [BE_WIDTH-1:0]   mem_be_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic                  mem_rvalid_i;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   modport slave (
      input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
      output cmd_ready_o,
      input  wdata_valid_i, wdata_i,
      output wdata_ready_o,
      output rdata_valid_o, rdata_o,
      input  rdata_ready_i,
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output busy_o, done_o, err_o
   );

   modport master (
      output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_len_i,
      input  cmd_ready_o,
      output wdata_valid_i, wdata_i,
      input  wdata_ready_o,
      input  rdata_valid_o, rdata_o,
      output rdata_ready_i,
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  busy_o, done_o, err_o
   );

endinterface

// File: rtl/jtag_bridge_rd_fifo.sv
// -----------------------------------------------------------------------------
// jtag_bridge_rd_fifo
// Small synchronous FIFO buffering read responses toward the TAP.
//   clk_i, rst_i : clock, async active-high reset
//   push_i/data_i: write side (caller guarantees never full on push)
//   pop_i/data_o : read side, data_o is the head (show-ahead)
//   empty_o      : no entries
//   count_o      : number of entries, 0..DEPTH
// -----------------------------------------------------------------------------
module jtag_bridge_rd_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    push_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic                    pop_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic [AW-1:0]                    wr_q, rd_q;
   logic [CW-1:0]                    cnt_q;
   logic                             do_pop;

   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
      end
   end

   // The credit rule upstream makes overflow structurally impossible.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && cnt_q == CW'(DEPTH)));

endmodule

// File: rtl/jtag_mem_burst_bridge.sv
// -----------------------------------------------------------------------------
// jtag_mem_burst_bridge
// Clock-domain engine behind the debug TAP: turns {we, addr, len} burst
// commands into word transactions on an OBI/TCDM-style memory port.
//   clk_i, rst_i : clock, async active-high reset
//   bus (slave)  : cmd stream, wdata stream, rdata stream, memory port,
//                  busy/done/err status
// Reads are credit-limited so in-flight responses always fit in the read FIFO.
// -----------------------------------------------------------------------------
module jtag_mem_burst_bridge
   import jtag_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_BURST     = 256,
   parameter int RD_FIFO_DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   jtag_mem_burst_bridge_if.slave   bus
);
   localparam int LEN_WIDTH = $clog2(MAX_BURST);
   localparam int BE_WIDTH  = be_width(DATA_WIDTH);
   localparam int OFF_W     = off_bits(DATA_WIDTH);
   localparam int CNT_W     = LEN_WIDTH + 1;   // holds len+1 up to MAX_BURST
   localparam int FCNT_W    = $clog2(RD_FIFO_DEPTH) + 1;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]      rem_q;
   logic [CNT_W-1:0]      out_q, out_d;
   logic                  we_q;
   logic                  done_q;

   logic                  mem_req, grant, push, pop;
   logic                  fifo_empty;
   logic [FCNT_W-1:0]     fifo_cnt;
   logic [DATA_WIDTH-1:0] fifo_head;

   always_comb begin
      mem_req = 1'b0;
      unique case (state_q)
         ST_WRITE: mem_req = bus.wdata_valid_i;
         // Credit: every in-flight read plus every buffered word owns a slot.
         ST_READ:  mem_req = (rem_q != '0) &&
                             ((out_q + CNT_W'(fifo_cnt)) < CNT_W'(RD_FIFO_DEPTH));
         default:  mem_req = 1'b0;
      endcase
   end

   assign grant = mem_req & bus.mem_gnt_i;
   assign push  = bus.mem_rvalid_i &
                  ((state_q == ST_READ) || ((state_q == ST_DRAIN) && !we_q));
   assign pop   = ~fifo_empty & bus.rdata_ready_i;
   // Grant and response in the same cycle cancel out.
   assign out_d = out_q + CNT_W'(grant) - CNT_W'(bus.mem_rvalid_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         out_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         out_q  <= out_d;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.cmd_valid_i) begin
                  if (bus.cmd_addr_i[OFF_W-1:0] != '0) begin
                     state_q <= ST_ERR;
                  end else begin
                     addr_q  <= bus.cmd_addr_i;
                     rem_q   <= CNT_W'(bus.cmd_len_i) + CNT_W'(1);
                     out_q   <= '0;
                     we_q    <= bus.cmd_we_i;
                     state_q <= bus.cmd_we_i ? ST_WRITE : ST_READ;
                  end
               end
            end
            ST_WRITE, ST_READ: begin
               if (grant) begin
                  addr_q <= addr_q + ADDR_WIDTH'(BE_WIDTH);
                  rem_q  <= rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (out_q == '0 && (we_q || fifo_empty)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_ERR:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   jtag_bridge_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (bus.mem_rdata_i),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign bus.cmd_ready_o   = (state_q == ST_IDLE);
   assign bus.busy_o        = (state_q != ST_IDLE);
   assign bus.err_o         = (state_q == ST_ERR);
   assign bus.done_o        = done_q;
   assign bus.mem_req_o     = mem_req;
   assign bus.mem_we_o      = (state_q == ST_WRITE);
   assign bus.mem_addr_o    = addr_q;
   assign bus.mem_be_o      = '1;
   assign bus.mem_wdata_o   = (state_q == ST_WRITE) ? bus.wdata_i : '0;
   assign bus.wdata_ready_o = (state_q == ST_WRITE) & grant;
   assign bus.rdata_valid_o = ~fifo_empty;
   assign bus.rdata_o       = fifo_head;

endmodule
